// File: rtl/filter_load_ctrl.sv
// Filter-load initiator: accepts weight beats over valid/ready and sequences them into the PE array.
// Optional configuration checking (ERR state, cfg_err) is enabled by defining FLC_CFG_CHECK_EN.
module filter_load_ctrl #(
    parameter int MAX_FILTERNUM   = 64,
    parameter int MAX_KERNELNUM   = 8,
    parameter int FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1,
    parameter int KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1,
    parameter int DATA_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [FILTERNUM_WIDTH-1:0] num_filter,
    input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
    input  logic [DATA_WIDTH-1:0]      w_data,
    input  logic                       w_valid,
    output logic                       w_ready,
    output logic                       filter_load,
    output logic [FILTERNUM_WIDTH-1:0] filter_cnt,
    output logic [KERNELNUM_WIDTH-1:0] filter_kernel,
    output logic [FILTERNUM_WIDTH-1:0] filter_row,
    output logic [DATA_WIDTH-1:0]      pe_wdata,
    output logic                       pe_we,
    output logic                       busy,
    output logic                       load_done,
    output logic                       cfg_err
);

    localparam int FW = FILTERNUM_WIDTH;
    localparam int KW = KERNELNUM_WIDTH;
    localparam logic [FW-1:0] F_ONE = 1;
    localparam logic [KW-1:0] K_ONE = 1;

`ifdef FLC_CFG_CHECK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;
`endif

    state_e          state_q;
    logic [FW-1:0]   num_filter_q;
    logic [KW-1:0]   num_kernel_q;
    logic [FW-1:0]   beat_q;   // index of the next beat to accept
    logic [KW-1:0]   kern_q;
    logic [FW-1:0]   row_q;
    logic            w_ready_q;
    logic            filter_load_q;
    logic [FW-1:0]   filter_cnt_q;
    logic [KW-1:0]   filter_kernel_q;
    logic [FW-1:0]   filter_row_q;
    logic [DATA_WIDTH-1:0] pe_wdata_q;
    logic            pe_we_q;
    logic            busy_q;
    logic            load_done_q;

    // w_ready_q is only ever high in LOAD, so it doubles as the state qualifier.
    logic accept;
    logic last_beat;
    logic kern_wrap;
    assign accept    = w_valid && w_ready_q;
    assign last_beat = (beat_q + F_ONE) == num_filter_q;
    assign kern_wrap = (kern_q + K_ONE) == num_kernel_q;

`ifdef FLC_CFG_CHECK_EN
    logic cfg_illegal;
    logic cfg_err_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cfg_illegal = 1'b0;
        if (num_kernel == '0 || num_kernel > KW'(MAX_KERNELNUM)) begin
            cfg_illegal = 1'b1;
        end else if (num_filter == '0 || num_filter > FW'(MAX_FILTERNUM)) begin
            cfg_illegal = 1'b1;
        end else if ((num_filter % FW'(num_kernel)) != '0) begin
            cfg_illegal = 1'b1;
        end
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            num_filter_q    <= '0;
            num_kernel_q    <= '0;
            beat_q          <= '0;
            kern_q          <= '0;
            row_q           <= '0;
            w_ready_q       <= 1'b0;
            filter_load_q   <= 1'b1;
            filter_cnt_q    <= '0;
            filter_kernel_q <= '0;
            filter_row_q    <= '0;
            pe_wdata_q      <= '0;
            pe_we_q         <= 1'b0;
            busy_q          <= 1'b0;
            load_done_q     <= 1'b0;
`ifdef FLC_CFG_CHECK_EN
            cfg_err_q       <= 1'b0;
`endif
        end else begin
            pe_we_q     <= 1'b0;
            load_done_q <= 1'b0;
            if (abort) begin
                // Abort drops any beat accepted this cycle; cfg_err survives until rst or the next start.
                state_q         <= ST_IDLE;
                w_ready_q       <= 1'b0;
                filter_load_q   <= 1'b1;
                busy_q          <= 1'b0;
                beat_q          <= '0;
                kern_q          <= '0;
                row_q           <= '0;
                filter_cnt_q    <= '0;
                filter_kernel_q <= '0;
                filter_row_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            num_filter_q    <= num_filter;
                            num_kernel_q    <= num_kernel;
                            beat_q          <= '0;
                            kern_q          <= '0;
                            row_q           <= '0;
                            filter_cnt_q    <= '0;
                            filter_kernel_q <= '0;
                            filter_row_q    <= '0;
`ifdef FLC_CFG_CHECK_EN
                            if (cfg_illegal) begin
                                state_q   <= ST_ERR;
                                cfg_err_q <= 1'b1;
                            end else begin
                                state_q       <= ST_LOAD;
                                cfg_err_q     <= 1'b0;
                                w_ready_q     <= 1'b1;
                                filter_load_q <= 1'b0;
                                busy_q        <= 1'b1;
                            end
`else
                            state_q       <= ST_LOAD;
                            w_ready_q     <= 1'b1;
                            filter_load_q <= 1'b0;
                            busy_q        <= 1'b1;
`endif
                        end
                    end
                    ST_LOAD: begin
                        if (accept) begin
                            pe_we_q         <= 1'b1;
                            pe_wdata_q      <= w_data;
                            filter_cnt_q    <= beat_q;
                            filter_kernel_q <= kern_q;
                            filter_row_q    <= row_q;
                            beat_q          <= beat_q + F_ONE;
                            if (kern_wrap) begin
                                kern_q <= '0;
                                row_q  <= row_q + F_ONE;
                            end else begin
                                kern_q <= kern_q + K_ONE;
                            end
                            if (last_beat) begin
                                state_q     <= ST_DONE;
                                w_ready_q   <= 1'b0;
                                load_done_q <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q       <= ST_IDLE;
                        filter_load_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
`ifdef FLC_CFG_CHECK_EN
                    ST_ERR: begin
                        state_q <= ST_ERR;
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_ready       = w_ready_q;
    assign filter_load   = filter_load_q;
    assign filter_cnt    = filter_cnt_q;
    assign filter_kernel = filter_kernel_q;
    assign filter_row    = filter_row_q;
    assign pe_wdata      = pe_wdata_q;
    assign pe_we         = pe_we_q;
    assign busy          = busy_q;
    assign load_done     = load_done_q;

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Self-checking bench for filter_load_ctrl: directed scenarios plus randomized loads against a beat-indexed reference model.
module tb_filter_load_ctrl;

    localparam int FW = 7;
    localparam int KW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [FW-1:0] num_filter;
    logic [KW-1:0] num_kernel;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          filter_load;
    logic [FW-1:0] filter_cnt;
    logic [KW-1:0] filter_kernel;
    logic [FW-1:0] filter_row;
    logic [DW-1:0] pe_wdata;
    logic          pe_we;
    logic          busy;
    logic          load_done;
    logic          cfg_err;

    int tests_run = 0;
    int tests_failed = 0;

    filter_load_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .num_filter    (num_filter),
        .num_kernel    (num_kernel),
        .w_data        (w_data),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .filter_load   (filter_load),
        .filter_cnt    (filter_cnt),
        .filter_kernel (filter_kernel),
        .filter_row    (filter_row),
        .pe_wdata      (pe_wdata),
        .pe_we         (pe_we),
        .busy          (busy),
        .load_done     (load_done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fload"},  filter_load,   1);
        check({tag, "_ready"},  w_ready,       0);
        check({tag, "_we"},     pe_we,         0);
        check({tag, "_wdata"},  pe_wdata,      0);
        check({tag, "_cnt"},    filter_cnt,    0);
        check({tag, "_kern"},   filter_kernel, 0);
        check({tag, "_row"},    filter_row,    0);
        check({tag, "_busy"},   busy,          0);
        check({tag, "_done"},   load_done,     0);
        check({tag, "_cfgerr"}, cfg_err,       0);
    endtask

    // mode: 0 = w_valid always high, 1 = alternate cycles, 2 = random 60 %.
    // abort_after >= 0 aborts once that many beats have been accepted.
    task automatic run_load(input int nf, input int nk, input int mode, input int abort_after, input bit start_mid);
        int          acc;
        int          cyc;
        logic        v;
        logic [DW-1:0] d;
        start = 1'b1;
        num_filter = FW'(nf);
        num_kernel = KW'(nk);
        tick();
        start = 1'b0;
        check("start_ready", w_ready, 1);
        check("start_busy", busy, 1);
        check("start_fload", filter_load, 0);
        check("start_cnt", filter_cnt, 0);
        check("start_kern", filter_kernel, 0);
        check("start_row", filter_row, 0);
        check("start_cfgerr", cfg_err, 0);
        acc = 0;
        cyc = 0;
        while (acc < nf && cyc < 4 * nf + 20) begin
            if (abort_after >= 0 && acc == abort_after) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 99) < 60);
            endcase
            d = DW'($urandom);
            w_valid = v;
            w_data = d;
            num_filter = FW'($urandom);
            num_kernel = KW'($urandom);
            start = start_mid && (cyc == 2);
            check("load_ready", w_ready, 1);
            tick();
            start = 1'b0;
            if (v) begin
                check("beat_we", pe_we, 1);
                check("beat_wdata", pe_wdata, d);
                check("beat_cnt", filter_cnt, acc);
                check("beat_kern", filter_kernel, acc % nk);
                check("beat_row", filter_row, acc / nk);
                check("beat_done", load_done, (acc == nf - 1) ? 1 : 0);
                acc++;
            end else begin
                check("gap_we", pe_we, 0);
                check("gap_done", load_done, 0);
                if (acc > 0) check("gap_cnt_hold", filter_cnt, acc - 1);
            end
            cyc++;
        end
        w_valid = 1'b0;
        if (abort_after >= 0) begin
            abort = 1'b1;
            w_valid = 1'b1;
            w_data = DW'($urandom);
            tick();
            abort = 1'b0;
            check("abort_we", pe_we, 0);
            check("abort_done", load_done, 0);
            check("abort_ready", w_ready, 0);
            check("abort_busy", busy, 0);
            check("abort_fload", filter_load, 1);
            check("abort_cnt", filter_cnt, 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                check("post_abort_we", pe_we, 0);
                check("post_abort_done", load_done, 0);
            end
            w_valid = 1'b0;
        end else begin
            check("load_beats", acc, nf);
            check("done_busy", busy, 1);
            check("done_ready", w_ready, 0);
            check("done_fload", filter_load, 0);
            tick();
            check("idle_fload", filter_load, 1);
            check("idle_busy", busy, 0);
            check("idle_done", load_done, 0);
            check("idle_we", pe_we, 0);
            check("idle_cnt_hold", filter_cnt, nf - 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_filter = '0;
        num_kernel = '0;
        w_data = '0;
        w_valid = 1'b0;
        repeat (3) tick();
        check_reset_values("rst");
        rst = 1'b0;
        tick();
        check_reset_values("idle");

        run_load(16, 4, 0, -1, 1'b0);
        run_load(16, 4, 1, -1, 1'b0);
        run_load(16, 4, 0, 5, 1'b0);
        run_load(16, 4, 0, -1, 1'b1);

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        num_filter = 7'd16;
        num_kernel = 4'd4;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_ready", w_ready, 0);
        check("sa_busy", busy, 0);
        check("sa_fload", filter_load, 1);
        w_valid = 1'b1;
        tick();
        check("sa_we", pe_we, 0);
        check("sa_ready2", w_ready, 0);
        w_valid = 1'b0;

        // rst in the middle of a load
        start = 1'b1;
        tick();
        start = 1'b0;
        w_valid = 1'b1;
        repeat (3) begin
            w_data = DW'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        check_reset_values("rst_mid");
        rst = 1'b0;
        w_valid = 1'b0;
        tick();

`ifdef FLC_CFG_CHECK_EN
        start = 1'b1;
        num_filter = 7'd10;
        num_kernel = 4'd4;
        tick();
        start = 1'b0;
        check("cfg_err_set", cfg_err, 1);
        check("cfg_ready", w_ready, 0);
        check("cfg_busy", busy, 0);
        w_valid = 1'b1;
        repeat (3) begin
            tick();
            check("cfg_hold_err", cfg_err, 1);
            check("cfg_hold_ready", w_ready, 0);
            check("cfg_hold_we", pe_we, 0);
            check("cfg_hold_done", load_done, 0);
        end
        w_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cfg_err_clr", cfg_err, 0);
        tick();
`endif

        for (int n = 0; n < 12; n++) begin
            int nk;
            int nf;
            nk = $urandom_range(1, 8);
            nf = nk * $urandom_range(1, 64 / nk);
            run_load(nf, nk, (n % 3 == 0) ? 0 : 2, -1, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
